resp_rtc: RTL and testbench
===========================

RESP_RTC -- requirements
Module: resp_rtc

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth applied to every bus input.
REQ-002 Parameter N_REGS, default 16: register file depth; the decoded address range is 0x00..N_REGS-1.
REQ-003 reloj  in  1  system clock; all logic is on the rising edge.
REQ-004 resetM  in  1  reset, asynchronous assert, active-low; logic resets while resetM=0.
REQ-005 CS  in  1  chip select from the bus master, active-low.
REQ-006 RD  in  1  read strobe, active-low.
REQ-007 WR  in  1  write strobe, active-low.
REQ-008 A_D  in  1  phase select: 0 = address phase, 1 = data phase.
REQ-009 dato_in  in  8  multiplexed address/data driven by the master.
REQ-010 tick_1hz  in  1  one-cycle pulse that advances the time-of-day registers.
REQ-011 dato_out  out  8  read data toward the master.
REQ-012 dato_oe  out  1  1 = dato_out valid; the bus driver is enabled.

Function
REQ-013 CS, RD, WR, A_D and dato_in SHALL pass through SYNC_STAGES flops before any use.
REQ-014 The FSM SHALL have states IDLE, ADDR, WDATA, RDATA, driven only by the synchronized signals.
REQ-015 IDLE->ADDR SHALL occur when CS=0, WR=0, RD=1, A_D=0.
REQ-016 IDLE->WDATA SHALL occur when CS=0, WR=0, RD=1, A_D=1.
REQ-017 IDLE->RDATA SHALL occur when CS=0, RD=0, WR=1, A_D=1.
REQ-018 ADDR or WDATA SHALL commit on the first cycle WR=1 or CS=1, then return to IDLE.
REQ-019 The commit SHALL use the dato_in value sampled on the last cycle WR=0.
REQ-020 ADDR commit SHALL load the 8-bit address register; the address persists until the next address phase.
REQ-021 WDATA commit SHALL write reg[addr] only when addr < N_REGS; otherwise the data is discarded.
REQ-022 In RDATA, dato_oe SHALL be 1 and dato_out SHALL equal reg[addr], or 0xFF when addr >= N_REGS, both registered.
REQ-023 RDATA SHALL exit to IDLE on the first cycle RD=1 or CS=1; dato_oe SHALL be 0 the following cycle.
REQ-024 dato_oe SHALL rise exactly SYNC_STAGES+1 cycles after raw RD falls, with CS=0 and A_D=1 already stable.
REQ-025 Simultaneous RD=0 and WR=0 SHALL keep or force IDLE, with no write and no drive.
REQ-026 Outside RDATA, dato_oe SHALL be 0 and dato_out SHALL hold 0x00.
REQ-027 reg[0], reg[1], reg[2] SHALL hold packed BCD seconds 00-59, minutes 00-59 and hours 00-23.
REQ-028 On tick_1hz, seconds SHALL increment in BCD; the wrap 59->00 carries into minutes.
REQ-029 Minutes SHALL wrap 59->00 and carry into hours; hours SHALL wrap 23->00.
REQ-030 A WDATA commit to reg[k] in the same cycle as a tick SHALL win for reg[k]; the tick still updates every other affected register.
REQ-031 Non-BCD values written to time registers SHALL be stored as written.
REQ-032 A tick on an invalid time value SHALL force that field to 00 and carry.

Reset
REQ-033 While resetM=0, all registers SHALL be 0x00, the address SHALL be 0x00 and the state SHALL be IDLE.
REQ-034 While resetM=0, dato_oe SHALL be 0, dato_out SHALL be 0x00 and the synchronizers SHALL be cleared to the idle level (strobes 1, A_D 1, data 0x00).
REQ-035 Reset asserted mid-cycle SHALL abort the transfer with no partial write; after release, the block SHALL wait for all strobes to be 1 before leaving IDLE.

Structure
REQ-036 Package rtc_pkg SHALL hold: state encoding; register indices SEC=0, MIN=1, HORA=2; BCD limits 0x59 and 0x23; the out-of-range read value 0xFF.
REQ-037 Sub-module sincronizador (parameterized-width SYNC_STAGES flop chain) SHALL be instantiated once for the strobes and once for dato_in.
REQ-038 The BCD increment/carry logic SHALL live in resp_rtc.

Verification (10 ns clock)
REQ-039 Address phase 0x01 then data phase 0x45 -> reg[1]=0x45; no dato_oe pulse.
REQ-040 Address phase 0x01 then read phase (RD low 100 ns) -> dato_oe=1 with dato_out=0x45 exactly 3 cycles after RD falls; dato_oe=0 within 4 cycles of RD rising.
REQ-041 Regs set to 23:59:59, one tick_1hz -> reg[2..0] = 0x00, 0x00, 0x00.
REQ-042 Address phase 0x20 then write 0x77 then read -> no register changes; the read returns 0xFF.
REQ-043 RD and WR both held low with CS low -> state stays IDLE, dato_oe=0, no register changes.
REQ-044 resetM pulsed low during WDATA of 0x12 to reg[0] -> reg[0]=0x00, dato_oe=0, and the next clean transaction succeeds.

Source files
------------

// File: rtl/rtc_pkg.sv
// ---------------------------------------------------------------------------
// rtc_pkg
// Shared definitions for the bus-attached real-time-clock register block:
// bus FSM state encoding, register indices of the time-of-day fields, packed
// BCD field limits and the value returned for reads outside the register file.
// ---------------------------------------------------------------------------
package rtc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_t;

    // Time-of-day register indices
    localparam int SEC  = 0;
    localparam int MIN  = 1;
    localparam int HORA = 2;

    // Packed BCD maximum of each field
    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HORA_MAX = 8'h23;

    // Read value for an address beyond the register file
    localparam logic [7:0] RD_OOR = 8'hFF;

endpackage

// File: rtl/sincronizador.sv
// ---------------------------------------------------------------------------
// sincronizador
// STAGES-deep flop chain that brings an asynchronous bus signal group into
// the reloj domain. The chain resets to RST_VAL so that, while in reset, the
// downstream logic sees the bus at its idle level.
//
// Ports
//   reloj   in  1      system clock, rising edge
//   resetM  in  1      asynchronous active-low reset
//   d       in  WIDTH  asynchronous input
//   q       out WIDTH  synchronized output (STAGES cycles of latency)
// ---------------------------------------------------------------------------
module sincronizador #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             reloj,
    input  logic             resetM,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain_q [STAGES];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the value its predecessor held before the clock edge.
    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            for (int i = 0; i < STAGES; i++) chain_q[i] <= RST_VAL;
        end else begin
            chain_q[0] <= d;
            for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/resp_rtc.sv
// ---------------------------------------------------------------------------
// resp_rtc
// Register block on a multiplexed, asynchronous address/data bus. Holds an
// N_REGS x 8 register file whose first three entries are a packed-BCD
// time-of-day counter (seconds, minutes, hours) advanced by tick_1hz.
//
// Ports
//   reloj     in  1  system clock, rising edge
//   resetM    in  1  asynchronous active-low reset
//   CS        in  1  chip select, active-low
//   RD        in  1  read strobe, active-low
//   WR        in  1  write strobe, active-low
//   A_D       in  1  0 = address phase, 1 = data phase
//   dato_in   in  8  multiplexed address/data from the master
//   tick_1hz  in  1  one-cycle pulse advancing the time of day
//   dato_out  out 8  read data (0x00 when not reading)
//   dato_oe   out 1  bus driver enable, high only in a read data phase
// ---------------------------------------------------------------------------
module resp_rtc
    import rtc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int N_REGS      = 16
) (
    input  logic       reloj,
    input  logic       resetM,
    input  logic       CS,
    input  logic       RD,
    input  logic       WR,
    input  logic       A_D,
    input  logic [7:0] dato_in,
    input  logic       tick_1hz,
    output logic [7:0] dato_out,
    output logic       dato_oe
);

    localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;

    // ---------------- synchronized bus ----------------
    logic [3:0] ctl_s;
    logic       cs_s, rd_s, wr_s, ad_s;
    logic [7:0] din_s;

    sincronizador #(.WIDTH(4), .STAGES(SYNC_STAGES), .RST_VAL(4'b1111)) u_sync_ctl (
        .reloj (reloj),
        .resetM(resetM),
        .d     ({CS, RD, WR, A_D}),
        .q     (ctl_s)
    );

    sincronizador #(.WIDTH(8), .STAGES(SYNC_STAGES), .RST_VAL(8'h00)) u_sync_dat (
        .reloj (reloj),
        .resetM(resetM),
        .d     (dato_in),
        .q     (din_s)
    );

    assign {cs_s, rd_s, wr_s, ad_s} = ctl_s;

    // ---------------- state ----------------
    state_t     state_q, next_state;
    logic [7:0] regs_q [N_REGS];
    logic [7:0] addr_q;
    logic [7:0] hold_q;        // dato_in as seen on the latest WR=0 cycle
    logic [7:0] flush_cnt_q;   // cycles since reset release, saturating
    logic       armed_q;       // strobes seen idle since reset release

    logic             commit_addr, commit_wr, both_low, flushed, addr_ok;
    logic [7:0]       commit_data, rd_val;
    logic [IDX_W-1:0] addr_idx;

    // The synchronizer chain still holds reset values until it has been
    // refilled; only after that can "all strobes idle" be trusted.
    assign flushed     = (flush_cnt_q == 8'(SYNC_STAGES));
    assign both_low    = !rd_s && !wr_s;
    assign addr_ok     = (int'(addr_q) < N_REGS);
    assign addr_idx    = addr_q[IDX_W-1:0];
    assign rd_val      = addr_ok ? regs_q[addr_idx] : RD_OOR;
    // A commit caused by CS rising while WR is still low uses this cycle's data.
    assign commit_data = wr_s ? hold_q : din_s;

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    always_comb begin
        next_state  = state_q;
        commit_addr = 1'b0;
        commit_wr   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (armed_q && !cs_s && !both_low) begin
                    if (!wr_s)           next_state = ad_s ? WDATA : ADDR;
                    else if (!rd_s && ad_s) next_state = RDATA;
                end
            end
            ADDR, WDATA: begin
                if (both_low) begin
                    next_state = IDLE;              // abort: no commit
                end else if (wr_s || cs_s) begin
                    next_state  = IDLE;
                    commit_addr = (state_q == ADDR);
                    commit_wr   = (state_q == WDATA);
                end
            end
            RDATA: begin
                if (rd_s || cs_s || both_low) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // ---------------- BCD time of day ----------------
    // Returns {carry, next}. A field at its limit, or holding a non-BCD or
    // out-of-range value, becomes 00 and carries.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        if (v[3:0] > 4'd9 || v >= lim) return {1'b1, 8'h00};
        else if (v[3:0] == 4'd9)       return {1'b0, v[7:4] + 4'd1, 4'h0};
        else                           return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    logic [8:0] sec_inc, min_inc, hora_inc;
    assign sec_inc  = bcd_inc(regs_q[SEC],  SEC_MAX);
    assign min_inc  = bcd_inc(regs_q[MIN],  MIN_MAX);
    assign hora_inc = bcd_inc(regs_q[HORA], HORA_MAX);

    // NOTE: the register file is reset explicitly because the time-of-day
    // and read-back values must be 0x00 while resetM is low.
    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            state_q     <= IDLE;
            addr_q      <= 8'h00;
            hold_q      <= 8'h00;
            flush_cnt_q <= 8'h00;
            armed_q     <= 1'b0;
            dato_oe     <= 1'b0;
            dato_out    <= 8'h00;
            for (int i = 0; i < N_REGS; i++) regs_q[i] <= 8'h00;
        end else begin
            state_q <= next_state;
            if (!flushed) flush_cnt_q <= flush_cnt_q + 8'd1;
            if (flushed && cs_s && rd_s && wr_s) armed_q <= 1'b1;
            if (!wr_s) hold_q <= din_s;

            if (tick_1hz) begin
                regs_q[SEC] <= sec_inc[7:0];
                if (sec_inc[8]) begin
                    regs_q[MIN] <= min_inc[7:0];
                    if (min_inc[8]) regs_q[HORA] <= hora_inc[7:0];
                end
            end

            if (commit_addr) addr_q <= commit_data;
            // Placed after the tick so a same-cycle bus write wins.
            if (commit_wr && addr_ok) regs_q[addr_idx] <= commit_data;

            dato_oe  <= (next_state == RDATA);
            dato_out <= (next_state == RDATA) ? rd_val : 8'h00;
        end
    end

endmodule

// File: tb/tb_resp_rtc.sv
// ---------------------------------------------------------------------------
// tb_resp_rtc
// Self-checking bench for resp_rtc: directed bus scenarios followed by a
// randomized mix of writes, reads and ticks, all compared against a
// behavioural register-file / clock model.
// ---------------------------------------------------------------------------
module tb_resp_rtc;
    import rtc_pkg::*;

    localparam int SYNC = 2;
    localparam int NR   = 16;

    logic       reloj = 1'b0;
    logic       resetM, CS, RD, WR, A_D, tick_1hz;
    logic [7:0] dato_in, dato_out;
    logic       dato_oe;

    resp_rtc #(.SYNC_STAGES(SYNC), .N_REGS(NR)) dut (
        .reloj   (reloj),
        .resetM  (resetM),
        .CS      (CS),
        .RD      (RD),
        .WR      (WR),
        .A_D     (A_D),
        .dato_in (dato_in),
        .tick_1hz(tick_1hz),
        .dato_out(dato_out),
        .dato_oe (dato_oe)
    );

    always #5 reloj = ~reloj;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model
    logic [7:0] m_reg [NR];
    logic [7:0] m_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) m_reg[i] = 8'h00;
        m_addr = 8'h00;
    endfunction

    // One decimal field step: {carry, next}
    function automatic logic [8:0] field_tick(input logic [7:0] v, input int max_dec);
        int hi, lo, d;
        hi = int'(v[7:4]);
        lo = int'(v[3:0]);
        d  = hi * 10 + lo;
        if (hi > 9 || lo > 9 || d >= max_dec) return {1'b1, 8'h00};
        d++;
        return {1'b0, 4'(d / 10), 4'(d % 10)};
    endfunction

    function automatic void model_tick();
        logic [8:0] r;
        r = field_tick(m_reg[0], 59);
        m_reg[0] = r[7:0];
        if (r[8]) begin
            r = field_tick(m_reg[1], 59);
            m_reg[1] = r[7:0];
            if (r[8]) begin
                r = field_tick(m_reg[2], 23);
                m_reg[2] = r[7:0];
            end
        end
    endfunction

    function automatic void model_commit(input bit ad, input logic [7:0] v);
        if (!ad) m_addr = v;
        else if (int'(m_addr) < NR) m_reg[m_addr] = v;
    endfunction

    task automatic idle_wait(inout bit oe_seen);
        repeat (SYNC + 3) begin
            @(posedge reloj); #1;
            if (dato_oe) oe_seen = 1'b1;
        end
    endtask

    // One write-strobed phase (ad=0 address, ad=1 data). With tick_commit the
    // tick pulse lands on the very cycle the DUT commits the phase.
    task automatic bus_write(input bit ad, input logic [7:0] v, input bit tick_commit, input string tag);
        bit oe_seen = 1'b0;
        @(posedge reloj); #1;
        CS = 1'b0; A_D = ad; WR = 1'b0; RD = 1'b1; dato_in = v;
        repeat (4) begin
            @(posedge reloj); #1;
            if (dato_oe) oe_seen = 1'b1;
        end
        WR = 1'b1;
        dato_in = 8'($urandom);   // must not be the committed value
        if (tick_commit) begin
            repeat (SYNC) @(posedge reloj);
            #1 tick_1hz = 1'b1;
            @(posedge reloj); #1 tick_1hz = 1'b0;
            model_tick();
        end
        @(posedge reloj); #1 CS = 1'b1;
        idle_wait(oe_seen);
        model_commit(ad, v);
        check({tag, "_no_oe"}, 32'(oe_seen), 32'd0);
    endtask

    task automatic bus_read(input logic [7:0] a, input string tag);
        int n;
        logic [7:0] exp;
        bus_write(1'b0, a, 1'b0, {tag, "_aph"});
        exp = (int'(m_addr) < NR) ? m_reg[m_addr] : RD_OOR;
        @(posedge reloj); #1 CS = 1'b0; A_D = 1'b1;
        @(posedge reloj); #1 RD = 1'b0;
        repeat (SYNC) @(posedge reloj);
        #1 check({tag, "_oe_early"}, 32'(dato_oe), 32'd0);
        @(posedge reloj); #1;
        check({tag, "_oe_rise"}, 32'(dato_oe), 32'd1);
        check({tag, "_data"}, 32'(dato_out), 32'(exp));
        repeat (7) @(posedge reloj);
        #1 RD = 1'b1;
        n = 0;
        do begin
            @(posedge reloj); #1 n++;
        end while (dato_oe && n < 4);
        check({tag, "_oe_fall"}, 32'(dato_oe), 32'd0);
        check({tag, "_dout_idle"}, 32'(dato_out), 32'd0);
        CS = 1'b1;
        repeat (SYNC + 2) @(posedge reloj);
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [7:0] v, input string tag);
        bus_write(1'b0, a, 1'b0, {tag, "_a"});
        bus_write(1'b1, v, 1'b0, {tag, "_d"});
    endtask

    task automatic tick_once();
        @(posedge reloj); #1 tick_1hz = 1'b1;
        @(posedge reloj); #1 tick_1hz = 1'b0;
        model_tick();
    endtask

    task automatic read_time(input string tag);
        bus_read(8'h00, {tag, "_sec"});
        bus_read(8'h01, {tag, "_min"});
        bus_read(8'h02, {tag, "_hora"});
    endtask

    initial begin
        resetM = 1'b0; CS = 1'b1; RD = 1'b1; WR = 1'b1; A_D = 1'b1;
        dato_in = 8'h00; tick_1hz = 1'b0;
        model_reset();
        repeat (3) @(posedge reloj);
        #1;
        check("rst_oe", 32'(dato_oe), 32'd0);
        check("rst_dout", 32'(dato_out), 32'd0);
        resetM = 1'b1;
        repeat (6) @(posedge reloj);

        bus_read(8'h00, "rst_reg0");

        // Basic write then read
        reg_write(8'h01, 8'h45, "wr_45");
        bus_read(8'h01, "rd_45");

        // Full roll-over 23:59:59 -> 00:00:00
        reg_write(8'h00, 8'h59, "set_s");
        reg_write(8'h01, 8'h59, "set_m");
        reg_write(8'h02, 8'h23, "set_h");
        tick_once();
        read_time("rollover");

        // Out-of-range address: write discarded, read returns 0xFF
        reg_write(8'h20, 8'h77, "oor_wr");
        bus_read(8'h20, "oor_rd");
        bus_read(8'h0F, "oor_top");

        // RD and WR low together: no transfer of any kind
        begin
            bit oe_seen = 1'b0;
            bit bad_state = 1'b0;
            @(posedge reloj); #1;
            CS = 1'b0; A_D = 1'b1; RD = 1'b0; WR = 1'b0; dato_in = 8'h99;
            repeat (8) begin
                @(posedge reloj); #1;
                if (dato_oe) oe_seen = 1'b1;
                if (dut.state_q != IDLE) bad_state = 1'b1;
            end
            RD = 1'b1; WR = 1'b1; CS = 1'b1;
            idle_wait(oe_seen);
            check("both_low_oe", 32'(oe_seen), 32'd0);
            check("both_low_state", 32'(bad_state), 32'd0);
            read_time("both_low");
        end

        // Write colliding with a tick: write wins, carry from old value
        reg_write(8'h00, 8'h59, "col_s");
        reg_write(8'h01, 8'h10, "col_m");
        bus_write(1'b0, 8'h00, 1'b0, "col_a");
        bus_write(1'b1, 8'h30, 1'b1, "col_d");
        read_time("collision");

        // Non-BCD values stored verbatim, then forced to 00 with carry
        reg_write(8'h00, 8'h7A, "nbcd_s");
        bus_read(8'h00, "nbcd_keep");
        reg_write(8'h01, 8'h99, "nbcd_m");
        reg_write(8'h02, 8'h05, "nbcd_h");
        tick_once();
        read_time("nbcd_tick");

        // Randomized mix
        for (int it = 0; it < 40; it++) begin
            int op;
            op = int'($urandom_range(0, 3));
            case (op)
                0: reg_write(8'($urandom_range(0, NR + 4)), 8'($urandom), "rnd_wr");
                1: reg_write(8'($urandom_range(0, 2)),
                             {4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))}, "rnd_tw");
                2: repeat ($urandom_range(1, 70)) tick_once();
                default: bus_read(8'($urandom_range(0, NR + 2)), "rnd_rd");
            endcase
        end
        read_time("rnd_end");

        // Reset in the middle of a data phase to reg[0]
        reg_write(8'h00, 8'h34, "prerst");
        bus_write(1'b0, 8'h00, 1'b0, "rst_a");
        @(posedge reloj); #1;
        CS = 1'b0; A_D = 1'b1; WR = 1'b0; RD = 1'b1; dato_in = 8'h12;
        repeat (4) @(posedge reloj);
        #3 resetM = 1'b0;
        #1;
        check("midrst_oe", 32'(dato_oe), 32'd0);
        check("midrst_dout", 32'(dato_out), 32'd0);
        repeat (2) @(posedge reloj);
        #1 resetM = 1'b1;
        model_reset();
        repeat (5) @(posedge reloj);   // strobes still low after release
        #1 WR = 1'b1; CS = 1'b1;
        repeat (SYNC + 3) @(posedge reloj);
        bus_read(8'h00, "midrst_reg0");
        reg_write(8'h03, 8'hA5, "postrst_wr");
        bus_read(8'h03, "postrst_rd");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
